dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Shares the single-port byte-addressable data memory between the pipeline MEM stage (CPU port) and a DMA/loader port. Arbitration is fixed-priority to the CPU, with starvation protection and bounded locked bursts for the DMA. The block drives the memory's write enable, address, write data and byte-select signals. It registers read data per port and produces the CPU stall signal used by the hazard unit.

Parameters:
DATA_WIDTH, 32, width of address and data buses
WAIT_MAX, 8, DMA starvation threshold in consecutive denied cycles (>=1)
BURST_MAX, 16, maximum consecutive DMA grants while locked (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
cpu_req  in  1  CPU access request
cpu_we  in  1  CPU write (1) / read (0)
cpu_byte  in  1  CPU byte access (SB/LBU), else word
cpu_addr  in  DATA_WIDTH  CPU byte address
cpu_wdata  in  DATA_WIDTH  CPU store data
cpu_gnt  out  1  CPU granted this cycle
cpu_stall  out  1  cpu_req & ~cpu_gnt
cpu_rdata  out  DATA_WIDTH  registered CPU read data
cpu_rvalid  out  1  cpu_rdata valid (1-cycle pulse)
dma_req  in  1  DMA access request
dma_lock  in  1  DMA requests a locked burst
dma_we  in  1  DMA write / read
dma_byte  in  1  DMA byte access
dma_addr  in  DATA_WIDTH  DMA byte address
dma_wdata  in  DATA_WIDTH  DMA store data
dma_gnt  out  1  DMA granted this cycle
dma_rdata  out  DATA_WIDTH  registered DMA read data
dma_rvalid  out  1  dma_rdata valid (1-cycle pulse)
mem_we  out  1  memory write enable
mem_a  out  DATA_WIDTH  memory address
mem_wd  out  DATA_WIDTH  memory write data
mem_byteaddr  out  1  memory byte-access select
mem_rd  in  DATA_WIDTH  memory asynchronous read data

Behaviour:
- One clock domain (clk); reset is synchronous and active-high (rst). While rst=1, both gnt=0 and mem_we=0.
- Reset values: state=CPU_PRI, wait_cnt=0, burst_cnt=0, cpu_rdata=dma_rdata=0, cpu_rvalid=dma_rvalid=0.
- Grants are combinational from state, counters and requests. At most one grant is high per cycle.
- State CPU_PRI:
  - starve = (wait_cnt == WAIT_MAX).
  - dma_gnt = dma_req & (starve | ~cpu_req).
  - cpu_gnt = cpu_req & ~dma_gnt.
- State DMA_BURST:
  - dma_gnt = dma_req.
  - cpu_gnt = 0 (CPU stalls).
- Transitions:
  - CPU_PRI->DMA_BURST when dma_gnt & dma_lock. Set burst_cnt=1.
  - DMA_BURST->CPU_PRI when ~dma_req, or ~dma_lock, or (dma_gnt & burst_cnt==BURST_MAX). Clear burst_cnt.
  - Otherwise, in DMA_BURST, burst_cnt increments on each dma_gnt.
- wait_cnt:
  - +1 (saturating at WAIT_MAX) on dma_req & ~dma_gnt.
  - Cleared on dma_gnt or ~dma_req.
  - Cleared on the DMA_BURST->CPU_PRI exit, so a pending CPU request wins the next cycle. This guarantees a CPU slot after every BURST_MAX beats.
- Memory mux:
  - The granted port's we/addr/wdata/byte drive mem_we/mem_a/mem_wd/mem_byteaddr, unmodified.
  - With no grant, all mem_* outputs are 0.
  - Writes commit at the posedge ending the grant cycle.
- Read path:
  - At the posedge of a read grant (gnt & ~we), port rdata <= mem_rd and port rvalid <= 1.
  - Otherwise rvalid <= 0 and rdata holds. Read latency is 1 cycle after grant.
  - Byte-read zero-extension is done by the memory; the arbiter passes mem_rd through.
- Write grants never raise rvalid.
- Requesters hold req and all request fields stable until gnt. Deasserting req without a grant is legal and has no side effects.
- Back-to-back grants to the same port are allowed every cycle (throughput 1 access/cycle).
- rst asserted mid-burst: return to CPU_PRI next cycle. Any read in flight is discarded (rvalid=0).

Test Plan:
1. cpu_req=1 read of 0x10000 (mem holds 0xDEADBEEF), dma idle -> cpu_gnt=1, cpu_stall=0, next cycle cpu_rvalid=1 and cpu_rdata=0xDEADBEEF.
2. cpu_req and dma_req both held high, dma_lock=0, WAIT_MAX=8 -> CPU granted cycles 0-7; dma_gnt=1 and cpu_stall=1 in cycle 8; CPU is granted again in cycle 9.
3. DMA locked burst with dma_lock=1, dma_req held for 20 cycles and cpu_req=1, BURST_MAX=16 -> after the first DMA grant, 16 consecutive dma_gnt; then exactly one cpu_gnt cycle; the DMA resumes under normal arbitration.
4. DMA SB of 0xAB to 0x00020 with dma_byte=1 -> mem_we=1, mem_byteaddr=1, mem_a=0x20, mem_wd=0x000000AB in the grant cycle; dma_rvalid stays 0.
5. No requests -> all mem_* outputs = 0 and both gnt = 0. Assert rst mid-burst at beat 5 -> state returns to CPU_PRI, counters = 0, rvalid = 0, and a pending cpu_req is granted in the first cycle after rst falls.

Source files
------------

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Lets the pipeline MEM stage (CPU port) and a DMA/loader port share a single
// port, byte-addressable data memory.
//
// Arbitration rules:
//   - The CPU has fixed priority.
//   - A DMA request that has been refused WAIT_MAX cycles in a row is granted
//     ahead of the CPU, so the DMA cannot be starved.
//   - A DMA grant taken with dma_lock set opens a locked burst. During the
//     burst the DMA owns the memory for up to BURST_MAX consecutive grants.
//     When the burst ends, a pending CPU request always wins the next cycle.
//
// The granted port's request fields drive the memory unchanged. Read data is
// captured per port one cycle after a read grant and flagged by a one-cycle
// rvalid pulse.
//
// Ports:
//   clk, rst       system clock; synchronous, active-high reset
//   cpu_*          CPU request (req/we/byte/addr/wdata), grant, stall and
//                  registered read data with its valid pulse
//   dma_*          DMA request (req/lock/we/byte/addr/wdata), grant and
//                  registered read data with its valid pulse
//   mem_*          memory write enable, address, write data, byte select;
//                  mem_rd is the memory's asynchronous read data
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int WAIT_MAX   = 8,   // starvation threshold, >= 1
  parameter int BURST_MAX  = 16   // longest locked burst, >= 1
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic                  cpu_byte,
  input  logic [DATA_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_stall,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_rvalid,

  input  logic                  dma_req,
  input  logic                  dma_lock,
  input  logic                  dma_we,
  input  logic                  dma_byte,
  input  logic [DATA_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic                  dma_gnt,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  dma_rvalid,

  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_a,
  output logic [DATA_WIDTH-1:0] mem_wd,
  output logic                  mem_byteaddr,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  // Counter widths: each counter must be able to hold its limit value.
  localparam int WCW = $clog2(WAIT_MAX + 1);
  localparam int BCW = $clog2(BURST_MAX + 1);

  localparam logic [WCW-1:0] WAIT_LIMIT  = WCW'(WAIT_MAX);
  localparam logic [BCW-1:0] BURST_LIMIT = BCW'(BURST_MAX);

  typedef enum logic [0:0] {
    CPU_PRI   = 1'b0,
    DMA_BURST = 1'b1
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [WCW-1:0] wait_cnt;    // consecutive cycles the DMA was refused
  logic [WCW-1:0] wait_next;
  logic [BCW-1:0] burst_cnt;   // DMA grants taken in the current burst
  logic [BCW-1:0] burst_next;
  logic           starve;
  logic           burst_exit;

  assign starve = (wait_cnt == WAIT_LIMIT);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) assignments only. Then every
  // flop samples the values from before the clock edge, whatever order the
  // blocks run in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CPU_PRI;
      wait_cnt  <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_next;
      wait_cnt  <= wait_next;
      burst_cnt <= burst_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Grant logic (FSM output decode)
  // ---------------------------------------------------------------------------
  // Reset masks both grants, so no memory write can slip out while the block
  // is being reset.
  // NOTE: every always_comb output gets a default before any branch. Otherwise
  // a path that leaves an output unassigned would infer a latch.
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (!rst) begin
      unique case (state)
        CPU_PRI: begin
          dma_gnt = dma_req & (starve | ~cpu_req);
          cpu_gnt = cpu_req & ~(dma_req & (starve | ~cpu_req));
        end
        DMA_BURST: begin
          dma_gnt = dma_req;
          cpu_gnt = 1'b0;
        end
        default: begin
          dma_gnt = 1'b0;
          cpu_gnt = 1'b0;
        end
      endcase
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;

  // ---------------------------------------------------------------------------
  // Next-state and counter logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    burst_next = burst_cnt;
    burst_exit = 1'b0;

    unique case (state)
      CPU_PRI: begin
        if (dma_gnt && dma_lock) begin
          state_next = DMA_BURST;
          burst_next = BCW'(1);   // the opening grant counts as beat 1
        end
      end
      DMA_BURST: begin
        if (!dma_req || !dma_lock || (dma_gnt && (burst_cnt == BURST_LIMIT))) begin
          state_next = CPU_PRI;
          burst_next = '0;
          burst_exit = 1'b1;
        end else if (dma_gnt) begin
          burst_next = burst_cnt + BCW'(1);
        end
      end
      default: begin
        state_next = CPU_PRI;
        burst_next = '0;
      end
    endcase

    // The count is cleared when a burst ends. A waiting CPU then wins the
    // next cycle, even if it asserted its request late in the burst.
    wait_next = wait_cnt;
    if (burst_exit || dma_gnt || !dma_req) begin
      wait_next = '0;
    end else if (!starve) begin
      wait_next = wait_cnt + WCW'(1);   // refused: count up, saturating
    end
  end

  // ---------------------------------------------------------------------------
  // Memory request mux
  // ---------------------------------------------------------------------------
  // When neither port is granted, the memory sees all zeros.
  always_comb begin
    mem_we       = 1'b0;
    mem_a        = '0;
    mem_wd       = '0;
    mem_byteaddr = 1'b0;
    if (cpu_gnt) begin
      mem_we       = cpu_we;
      mem_a        = cpu_addr;
      mem_wd       = cpu_wdata;
      mem_byteaddr = cpu_byte;
    end else if (dma_gnt) begin
      mem_we       = dma_we;
      mem_a        = dma_addr;
      mem_wd       = dma_wdata;
      mem_byteaddr = dma_byte;
    end
  end

  // ---------------------------------------------------------------------------
  // Read return path
  // ---------------------------------------------------------------------------
  // The memory reads asynchronously, so mem_rd is already valid during the
  // grant cycle. It is captured on the edge that ends that cycle. rdata keeps
  // its value between reads.
  // NOTE: the rdata registers are cleared on reset even though rvalid already
  // qualifies them. The ports then start from a known zero instead of
  // whatever the flops powered up with.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      cpu_rvalid <= cpu_gnt & ~cpu_we;
      dma_rvalid <= dma_gnt & ~dma_we;
      if (cpu_gnt && !cpu_we) begin
        cpu_rdata <= mem_rd;
      end
      if (dma_gnt && !dma_we) begin
        dma_rdata <= mem_rd;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------------
  a_one_grant : assert property (@(posedge clk) disable iff (rst)
    !(cpu_gnt && dma_gnt));

  a_we_needs_gnt : assert property (@(posedge clk) disable iff (rst)
    mem_we |-> (cpu_gnt || dma_gnt));

  a_burst_bound : assert property (@(posedge clk) disable iff (rst)
    (state == DMA_BURST) |-> (burst_cnt != '0) && (burst_cnt <= BURST_LIMIT));

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Testbench for dmem_arbiter.
//
// - The bench owns a behavioural memory: asynchronous read, write on the
//   clock edge, with byte-lane writes and zero-extended byte reads.
// - A reference model tracks three things: whether a locked burst is open,
//   how many beats it has used, and how long the DMA has been refused.
// - From those, the model derives the grants, the memory-bus values and the
//   expected read returns on every falling edge.
// - Directed phases drive fixed vectors and also check hand-computed literal
//   values.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int DW        = 32;
  localparam int WAIT_MAX  = 8;
  localparam int BURST_MAX = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, cpu_byte;
  logic [DW-1:0] cpu_addr, cpu_wdata;
  logic          cpu_gnt, cpu_stall, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          dma_req, dma_lock, dma_we, dma_byte;
  logic [DW-1:0] dma_addr, dma_wdata;
  logic          dma_gnt, dma_rvalid;
  logic [DW-1:0] dma_rdata;
  logic          mem_we, mem_byteaddr;
  logic [DW-1:0] mem_a, mem_wd, mem_rd;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .DATA_WIDTH(DW),
    .WAIT_MAX  (WAIT_MAX),
    .BURST_MAX (BURST_MAX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_byte    (cpu_byte),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_gnt     (cpu_gnt),
    .cpu_stall   (cpu_stall),
    .cpu_rdata   (cpu_rdata),
    .cpu_rvalid  (cpu_rvalid),
    .dma_req     (dma_req),
    .dma_lock    (dma_lock),
    .dma_we      (dma_we),
    .dma_byte    (dma_byte),
    .dma_addr    (dma_addr),
    .dma_wdata   (dma_wdata),
    .dma_gnt     (dma_gnt),
    .dma_rdata   (dma_rdata),
    .dma_rvalid  (dma_rvalid),
    .mem_we      (mem_we),
    .mem_a       (mem_a),
    .mem_wd      (mem_wd),
    .mem_byteaddr(mem_byteaddr),
    .mem_rd      (mem_rd)
  );

  // ---------------------------------------------------------------------------
  // Behavioural memory (64K words)
  // ---------------------------------------------------------------------------
  logic [31:0] mem [0:65535];
  logic [31:0] rd_word;

  always_comb begin
    rd_word = mem[mem_a[17:2]];
    mem_rd  = mem_byteaddr ? {24'h0, rd_word[8*mem_a[1:0] +: 8]} : rd_word;
  end

  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_byteaddr) mem[mem_a[17:2]][8*mem_a[1:0] +: 8] <= mem_wd[7:0];
      else              mem[mem_a[17:2]] <= mem_wd;
    end
  end

  // What a read of address a returns right now.
  function automatic logic [31:0] mem_peek(input logic [31:0] a, input logic b);
    logic [31:0] w;
    w = mem[a[17:2]];
    return b ? {24'h0, w[8*a[1:0] +: 8]} : w;
  endfunction

  // Compares actual against expected, counts the comparison, and reports
  // a failure. Only the first 40 failures are printed.
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model, checked on every falling edge
  // ---------------------------------------------------------------------------
  bit          m_locked;      // a locked DMA burst owns the memory
  int          m_beats;       // grants already taken in the open burst
  int          m_refused;     // consecutive cycles the DMA request was refused
  logic        m_cpu_rv, m_dma_rv;
  logic [31:0] m_cpu_rd, m_dma_rd;
  logic        e_cg, e_dg, e_we, e_b;
  logic [31:0] e_a, e_wd;
  bit          m_end;

  initial begin
    m_locked = 0; m_beats = 0; m_refused = 0;
    m_cpu_rv = 0; m_dma_rv = 0; m_cpu_rd = '0; m_dma_rd = '0;
  end

  always @(negedge clk) begin
    // Who should own the memory this cycle.
    if (rst) begin
      e_cg = 0; e_dg = 0;
    end else if (m_locked) begin
      e_dg = dma_req; e_cg = 0;
    end else begin
      // The DMA wins if the CPU is idle, or if it has waited long enough.
      e_dg = dma_req && (!cpu_req || m_refused >= WAIT_MAX);
      e_cg = cpu_req && !e_dg;
    end
    {e_we, e_a, e_wd, e_b} = '0;
    if (e_cg) begin e_we = cpu_we; e_a = cpu_addr; e_wd = cpu_wdata; e_b = cpu_byte; end
    if (e_dg) begin e_we = dma_we; e_a = dma_addr; e_wd = dma_wdata; e_b = dma_byte; end

    check("cmp_cpu_gnt",   cpu_gnt,   e_cg);
    check("cmp_dma_gnt",   dma_gnt,   e_dg);
    check("cmp_cpu_stall", cpu_stall, cpu_req && !e_cg);
    check("cmp_mem_ctl",   {mem_we, mem_byteaddr}, {e_we, e_b});
    check("cmp_mem_a",     mem_a,  e_a);
    check("cmp_mem_wd",    mem_wd, e_wd);
    check("cmp_cpu_rv",    cpu_rvalid, m_cpu_rv);
    check("cmp_cpu_rd",    cpu_rdata,  m_cpu_rd);
    check("cmp_dma_rv",    dma_rvalid, m_dma_rv);
    check("cmp_dma_rd",    dma_rdata,  m_dma_rd);

    // Advance the model to what the coming rising edge produces.
    if (rst) begin
      m_locked = 0; m_beats = 0; m_refused = 0;
      m_cpu_rv = 0; m_dma_rv = 0; m_cpu_rd = '0; m_dma_rd = '0;
    end else begin
      m_cpu_rv = e_cg && !cpu_we;
      if (m_cpu_rv) m_cpu_rd = mem_peek(cpu_addr, cpu_byte);
      m_dma_rv = e_dg && !dma_we;
      if (m_dma_rv) m_dma_rd = mem_peek(dma_addr, dma_byte);

      m_end = 0;
      if (!m_locked) begin
        if (e_dg && dma_lock) begin m_locked = 1; m_beats = 1; end
      end else if (!dma_req || !dma_lock || (e_dg && m_beats == BURST_MAX)) begin
        m_locked = 0; m_beats = 0; m_end = 1;
      end else begin
        m_beats++;
      end

      if (m_end || e_dg || !dma_req) m_refused = 0;
      else if (m_refused < WAIT_MAX) m_refused++;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();   // next rising edge, then drive new inputs
    @(posedge clk);
    #1;
  endtask

  task automatic settle(); // sample point, away from the active edge
    @(negedge clk);
  endtask

  task automatic idle();
    settle();
    tick();
  endtask

  initial begin
    int run;
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    mem[32'h10000 >> 2] = 32'hDEADBEEF;
    mem[32'h20 >> 2]    = 32'h11223344;
    mem[32'h40 >> 2]    = 32'h0BADF00D;

    // While in reset, requests are pending but nothing may be granted.
    rst = 1;
    cpu_req = 1; cpu_we = 1; cpu_byte = 0; cpu_addr = 32'h10000; cpu_wdata = 32'h55;
    dma_req = 1; dma_lock = 1; dma_we = 1; dma_byte = 0; dma_addr = 32'h40; dma_wdata = 32'h66;
    settle();
    check("rst_gnt",    {cpu_gnt, dma_gnt}, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_rvalid", {cpu_rvalid, dma_rvalid}, 0);
    check("rst_rdata",  cpu_rdata | dma_rdata, 0);
    tick(); tick();
    rst = 0;
    cpu_req = 0; cpu_we = 0; cpu_wdata = '0;
    dma_req = 0; dma_lock = 0; dma_we = 0; dma_wdata = '0;
    idle();

    // 1: single CPU word read, DMA idle.
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10000;
    settle();
    check("t1_cpu_gnt",   cpu_gnt, 1);
    check("t1_cpu_stall", cpu_stall, 0);
    check("t1_mem_a",     mem_a, 32'h10000);
    tick();
    cpu_req = 0;
    settle();
    check("t1_rvalid", cpu_rvalid, 1);
    check("t1_rdata",  cpu_rdata, 32'hDEADBEEF);
    tick();
    settle();
    check("t1_rvalid_pulse", cpu_rvalid, 0);
    tick();

    // 2: both request continuously, no lock. The DMA starves after 8
    //    refusals, wins cycle 8, and the CPU wins again in cycle 9.
    cpu_req = 1; cpu_addr = 32'h10000;
    dma_req = 1; dma_lock = 0; dma_we = 0; dma_addr = 32'h40;
    for (int i = 0; i < 10; i++) begin
      settle();
      check($sformatf("t2_gnt_c%0d", i), {cpu_gnt, dma_gnt}, (i == 8) ? 32'd1 : 32'd2);
      if (i == 8) check("t2_stall_c8", cpu_stall, 1);
      tick();
    end
    cpu_req = 0; dma_req = 0;
    settle();
    check("t2_dma_rdata", dma_rdata, 32'h0BADF00D);
    tick();
    idle();

    // 3: locked DMA burst against a busy CPU.
    //    Cycles 0-7   CPU.
    //    Cycle 8      DMA wins on starvation and opens the burst.
    //    Cycles 9-24  16 locked beats.
    //    Cycle 25     the CPU's guaranteed slot; the CPU then releases.
    //    Cycle 26     the DMA resumes under normal arbitration.
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10000;
    dma_req = 1; dma_lock = 1; dma_we = 1; dma_addr = 32'h100; dma_wdata = 32'h12345678;
    run = 0;
    for (int i = 0; i < 27; i++) begin
      settle();
      check($sformatf("t3_gnt_c%0d", i), {cpu_gnt, dma_gnt},
            (i < 8 || i == 25) ? 32'd2 : 32'd1);
      if (i >= 9 && i <= 25 && dma_gnt) run++;
      tick();
      if (i == 25) cpu_req = 0;
    end
    check("t3_burst_len", run, 16);
    dma_req = 0; dma_lock = 0; dma_we = 0;
    idle();

    // 4: DMA store-byte of 0xAB to 0x20, then CPU reads it back.
    dma_req = 1; dma_we = 1; dma_byte = 1; dma_addr = 32'h20; dma_wdata = 32'h000000AB;
    settle();
    check("t4_dma_gnt",   dma_gnt, 1);
    check("t4_mem_we",    mem_we, 1);
    check("t4_mem_byte",  mem_byteaddr, 1);
    check("t4_mem_a",     mem_a, 32'h20);
    check("t4_mem_wd",    mem_wd, 32'h000000AB);
    tick();
    dma_req = 0; dma_we = 0; dma_byte = 0;
    settle();
    check("t4_dma_rvalid", dma_rvalid, 0);
    tick();
    cpu_req = 1; cpu_we = 0; cpu_byte = 0; cpu_addr = 32'h20;
    settle();
    tick();
    cpu_byte = 1; cpu_addr = 32'h21;   // back-to-back: byte read of lane 1
    settle();
    check("t4_word_rd", cpu_rdata, 32'h112233AB);
    tick();
    cpu_req = 0; cpu_byte = 0;
    settle();
    check("t4_byte_rd", cpu_rdata, 32'h00000033);
    tick();

    // 5a: no requests, busy fields. The memory bus must read all zeros.
    cpu_addr = 32'h1234; cpu_wdata = 32'hFFFF0000; cpu_we = 1;
    dma_addr = 32'h5678; dma_wdata = 32'h0000FFFF; dma_we = 1; dma_byte = 1;
    settle();
    check("t5_idle_gnt", {cpu_gnt, dma_gnt}, 0);
    check("t5_idle_ctl", {mem_we, mem_byteaddr}, 0);
    check("t5_idle_a",   mem_a, 0);
    check("t5_idle_wd",  mem_wd, 0);
    tick();

    // 5b: reset during a locked write burst, after beat 5, with the CPU pending.
    cpu_we = 0; cpu_wdata = '0; cpu_addr = 32'h10000;
    dma_req = 1; dma_lock = 1; dma_we = 1; dma_byte = 0;
    dma_addr = 32'h80; dma_wdata = 32'hCAFE0000;
    for (int i = 0; i < 5; i++) begin
      settle();
      check($sformatf("t5_beat%0d", i + 1), dma_gnt, 1);
      tick();
    end
    rst = 1; cpu_req = 1;
    settle();
    check("t5_rst_gnt",   {cpu_gnt, dma_gnt}, 0);
    check("t5_rst_we",    mem_we, 0);
    check("t5_rst_stall", cpu_stall, 1);
    tick();
    rst = 0;
    settle();
    check("t5_post_gnt",    {cpu_gnt, dma_gnt}, 2);
    check("t5_post_rvalid", {cpu_rvalid, dma_rvalid}, 0);
    tick();
    cpu_req = 0;
    settle();
    check("t5_post_rdata", cpu_rdata, 32'hDEADBEEF);
    tick();
    dma_req = 0; dma_lock = 0; dma_we = 0;
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net: the run must always end on its own.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end, got timeout expected finish");
    $fatal(1);
  end

endmodule
